// File: rtl/elastic_pipe_pkg.sv
// Shared definitions for the elastic pipeline register: occupancy counter
// sizing and parameter legality helpers.
package elastic_pipe_pkg;

    localparam int unsigned MIN_WIDTH = 1;
    localparam int unsigned MIN_DEPTH = 1;

    // Bits needed to count 0..depth valid stages inclusive.
    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit params_legal(input int unsigned width, input int unsigned depth);
        return (width >= MIN_WIDTH) && (depth >= MIN_DEPTH);
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One stage of the elastic pipeline: a valid bit plus a data word. Loads from
// upstream when advanced; data only moves when the upstream word is valid.
module elastic_pipe_stage
    import elastic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_adv,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Stage state: flush drops the valid bit but keeps data; bubbles keep old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/elastic_pipeline_register.sv
// Elastic pipeline register: DEPTH stages of WIDTH bits with valid/ready flow
// control, bubble collapsing and synchronous flush.
// Optional feature: define ELASTIC_PIPE_OCCUPANCY_EN to add the registered
// occupancy output (count of valid stages).
module elastic_pipeline_register
    import elastic_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    ,
    output logic [occ_width(DEPTH)-1:0]    occupancy
`endif
);

    if (!params_legal(WIDTH, DEPTH)) begin : g_bad_params
        $error("elastic_pipeline_register: WIDTH and DEPTH must both be >= 1");
    end

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_adv;
    logic [WIDTH-1:0] w_data [DEPTH];

    // Advance chain: a stage moves if anything downstream moves or it holds a bubble.
    // Written as a running OR from the output end so the ready path stays flat.
    always_comb begin
        logic w_acc;
        w_acc = out_ready;
        w_adv = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            w_acc    = w_acc | ~w_valid[k];
            w_adv[k] = w_acc;
        end
    end

    assign in_ready = w_adv[0] & ~flush;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        if (k == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
        end else begin : g_body
            assign w_up_valid = w_valid[k-1];
            assign w_up_data  = w_data[k-1];
        end

        elastic_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_flush (flush),
            .i_adv   (w_adv[k]),
            .i_valid (w_up_valid),
            .i_data  (w_up_data),
            .o_valid (w_valid[k]),
            .o_data  (w_data[k])
        );
    end

    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];

`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    localparam int unsigned OCC_W = occ_width(DEPTH);

    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [OCC_W-1:0] r_occupancy;

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    // Occupancy tracks the number of valid stages; simultaneous in/out leaves it unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_occupancy <= '0;
        end else if (flush) begin
            r_occupancy <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occupancy <= r_occupancy + OCC_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occupancy <= r_occupancy - OCC_W'(1);
        end
    end

    assign occupancy = r_occupancy;
`endif

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Scoreboard bench for elastic_pipeline_register: three instances
// (W8/D2, W8/D3, W1/D1). Accepted words are queued; a negedge monitor pops
// and compares every output transfer.
module tb_elastic_pipeline_register;

    typedef struct {
        logic [7:0] data;
        int         exp_cyc;   // -1: no latency check
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic no_flush = 1'b0;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    logic       d2_flush, d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
    logic [7:0] d2_in_data, d2_out_data;
    logic       d3_in_valid, d3_in_ready, d3_out_valid, d3_out_ready;
    logic [7:0] d3_in_data, d3_out_data;
    logic       d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready;
    logic       d1_in_data, d1_out_data;
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
    logic [1:0] occ2, occ3;
    logic [0:0] occ1;
`endif

    exp_t q2[$];
    exp_t q3[$];
    exp_t q1[$];
    bit   lat2 = 1'b0;

    int         i;
    bit         hold;
    logic       held;
    logic [7:0] t1_words [3];
    logic [7:0] t6_bits;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    elastic_pipeline_register #(.WIDTH(8), .DEPTH(2)) u_d2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (d2_flush),
        .in_valid  (d2_in_valid),
        .in_ready  (d2_in_ready),
        .in_data   (d2_in_data),
        .out_valid (d2_out_valid),
        .out_ready (d2_out_ready),
        .out_data  (d2_out_data)
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occ2)
`endif
    );

    elastic_pipeline_register #(.WIDTH(8), .DEPTH(3)) u_d3 (
        .clk       (clk),
        .reset     (reset),
        .flush     (no_flush),
        .in_valid  (d3_in_valid),
        .in_ready  (d3_in_ready),
        .in_data   (d3_in_data),
        .out_valid (d3_out_valid),
        .out_ready (d3_out_ready),
        .out_data  (d3_out_data)
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occ3)
`endif
    );

    elastic_pipeline_register #(.WIDTH(1), .DEPTH(1)) u_d1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (no_flush),
        .in_valid  (d1_in_valid),
        .in_ready  (d1_in_ready),
        .in_data   (d1_in_data),
        .out_valid (d1_out_valid),
        .out_ready (d1_out_ready),
        .out_data  (d1_out_data)
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        ,
        .occupancy (occ1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: output transfer with empty scoreboard, expected none (t=%0t)",
                 name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each output transfer, then record each input transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (d2_out_valid && d2_out_ready) begin
                if (q2.size() == 0) unexpected("d2_out");
                else begin
                    e = q2.pop_front();
                    check("d2_data", d2_out_data, e.data);
                    if (e.exp_cyc >= 0) check("d2_latency", cyc, e.exp_cyc);
                end
            end
            if (d3_out_valid && d3_out_ready) begin
                if (q3.size() == 0) unexpected("d3_out");
                else begin
                    e = q3.pop_front();
                    check("d3_data", d3_out_data, e.data);
                end
            end
            if (d1_out_valid && d1_out_ready) begin
                if (q1.size() == 0) unexpected("d1_out");
                else begin
                    e = q1.pop_front();
                    check("d1_data", d1_out_data, e.data);
                end
            end
            if (d2_in_valid && d2_in_ready) begin
                e.data    = d2_in_data;
                e.exp_cyc = lat2 ? cyc + 2 : -1;
                q2.push_back(e);
            end
            if (d3_in_valid && d3_in_ready) begin
                e.data    = d3_in_data;
                e.exp_cyc = -1;
                q3.push_back(e);
            end
            if (d1_in_valid && d1_in_ready) begin
                e.data    = {7'b0, d1_in_data};
                e.exp_cyc = -1;
                q1.push_back(e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1);
    end

    initial begin
        d2_flush = 0; d2_in_valid = 0; d2_in_data = 0; d2_out_ready = 0;
        d3_in_valid = 0; d3_in_data = 0; d3_out_ready = 0;
        d1_in_valid = 0; d1_in_data = 0; d1_out_ready = 0;
        t1_words = '{8'h11, 8'h22, 8'h33};
        t6_bits  = 8'b0110_1101;

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst_d2_out_valid", d2_out_valid, 0);
        check("rst_d2_out_data", d2_out_data, 0);
        check("rst_d3_out_valid", d3_out_valid, 0);
        check("rst_d1_out_valid", d1_out_valid, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        tick();
        check("rst_d2_in_ready", d2_in_ready, 1);
        check("rst_d3_in_ready", d3_in_ready, 1);
        check("rst_d1_in_ready", d1_in_ready, 1);

        // 1: back-to-back words through DEPTH=2 with fixed latency
        lat2 = 1'b1;
        d2_out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d2_in_valid = 1'b1;
            d2_in_data  = t1_words[k];
            @(negedge clk);
            check("t1_in_ready", d2_in_ready, 1);
            tick();
        end
        d2_in_valid = 1'b0;
        repeat (4) tick();
        lat2 = 1'b0;
        check("t1_drained", q2.size(), 0);

        // 2: backpressure fills DEPTH=3 then drains in order
        d3_out_ready = 1'b0;
        i = 0;
        for (int c = 0; c < 5; c++) begin
            d3_in_valid = 1'b1;
            d3_in_data  = 8'hA0 + 8'(i);
            @(negedge clk);
            check("t2_in_ready", d3_in_ready, (c < 3));
            if (c >= 3) begin
                check("t2_out_valid", d3_out_valid, 1);
                check("t2_out_hold", d3_out_data, 8'hA0);
            end
            if (d3_in_ready) i++;
            tick();
        end
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        check("t2_occupancy", occ3, 3);
`endif
        d3_out_ready = 1'b1;
        for (int c = 0; c < 20 && i < 5; c++) begin
            d3_in_data = 8'hA0 + 8'(i);
            @(negedge clk);
            if (d3_in_ready) i++;
            tick();
        end
        d3_in_valid = 1'b0;
        repeat (5) tick();
        check("t2_all_accepted", i, 5);
        check("t2_drained", q3.size(), 0);

        // 3: full chain, simultaneous in/out for 4 cycles
        d3_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d3_in_valid = 1'b1;
            d3_in_data  = 8'hB0 + 8'(k);
            @(negedge clk);
            check("t3_fill_ready", d3_in_ready, 1);
            tick();
        end
        d3_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d3_in_data = 8'hB3 + 8'(k);
            @(negedge clk);
            check("t3_in_ready", d3_in_ready, 1);
            check("t3_out_valid", d3_out_valid, 1);
            tick();
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
            check("t3_occupancy", occ3, 3);
`endif
        end
        d3_in_valid = 1'b0;
        repeat (5) tick();
        check("t3_drained", q3.size(), 0);

        // 4: flush with two words held; output in flush cycle still consumed
        d2_out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            d2_in_valid = 1'b1;
            d2_in_data  = 8'hC1 + 8'(k);
            @(negedge clk);
            check("t4_fill_ready", d2_in_ready, 1);
            tick();
        end
        d2_flush     = 1'b1;
        d2_in_data   = 8'hEE;
        d2_out_ready = 1'b1;
        @(negedge clk);
        check("t4_flush_in_ready", d2_in_ready, 0);
        tick();
        d2_flush    = 1'b0;
        d2_in_valid = 1'b0;
        q2.delete();
        @(negedge clk);
        check("t4_out_valid", d2_out_valid, 0);
`ifdef ELASTIC_PIPE_OCCUPANCY_EN
        check("t4_occupancy", occ2, 0);
`endif
        tick();
        lat2        = 1'b1;
        d2_in_valid = 1'b1;
        d2_in_data  = 8'h5C;
        @(negedge clk);
        check("t4_in_ready", d2_in_ready, 1);
        tick();
        d2_in_valid = 1'b0;
        repeat (4) tick();
        lat2 = 1'b0;
        check("t4_drained", q2.size(), 0);

        // 5: asynchronous reset with full chain
        d2_out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            d2_in_valid = 1'b1;
            d2_in_data  = 8'hD1 + 8'(k);
            tick();
        end
        d2_in_valid = 1'b0;
        check("t5_full_before", d2_out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_valid", d2_out_valid, 0);
        check("t5_async_data", d2_out_data, 0);
        q2.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        tick();
        check("t5_in_ready", d2_in_ready, 1);
        lat2         = 1'b1;
        d2_out_ready = 1'b1;
        d2_in_valid  = 1'b1;
        d2_in_data   = 8'h77;
        tick();
        d2_in_valid = 1'b0;
        repeat (4) tick();
        lat2 = 1'b0;
        check("t5_drained", q2.size(), 0);

        // 6: DEPTH=1, WIDTH=1 with alternating out_ready
        i    = 0;
        hold = 1'b0;
        held = 1'b0;
        d1_in_valid = 1'b1;
        for (int c = 0; c < 24 && i < 8; c++) begin
            d1_out_ready = (c % 2 == 1);
            d1_in_data   = t6_bits[i];
            @(negedge clk);
            if (hold) begin
                check("t6_hold_valid", d1_out_valid, 1);
                check("t6_hold_data", d1_out_data, held);
            end
            if (c > 0) check("t6_in_ready", d1_in_ready, (c % 2 == 1));
            hold = d1_out_valid && !d1_out_ready;
            held = d1_out_data;
            if (d1_in_ready) i++;
            tick();
        end
        d1_in_valid  = 1'b0;
        d1_out_ready = 1'b1;
        repeat (3) tick();
        check("t6_all_accepted", i, 8);
        check("t6_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
